// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared defaults, clear-sequencer state encoding and pair-index
//               helpers for the banked index-register file.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int DEF_DATA_W    = 4;
    localparam int DEF_NUM_REGS  = 16;
    localparam int DEF_NUM_BANKS = 2;

    // Fixed width for the pair-index helpers; callers cast to their ADDR_W.
    localparam int IDX_FN_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    // Even register of pair p: {p, 0}
    function automatic logic [IDX_FN_W-1:0] evenIdx(input logic [IDX_FN_W-2:0] p);
        return {p, 1'b0};
    endfunction

    // Odd register of pair p: {p, 1}
    function automatic logic [IDX_FN_W-1:0] oddIdx(input logic [IDX_FN_W-2:0] p);
        return {p, 1'b1};
    endfunction

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_clr_seq.sv
`default_nettype none
// ============================================================================
// Module      : reg_clr_seq
// Description : Bank-clear sequencer. On clrStart it latches the bank and
//               sweeps every register index once, one per cycle, then pulses
//               clrDone for a single cycle before returning to idle.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_clr_seq
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int BANK_W   = 1,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clrStart,
    input  logic [BANK_W-1:0] bankSel,
    output logic              clrBusy,
    output logic              clrDone,
    output logic              clrWe,
    output logic [BANK_W-1:0] clrBank,
    output logic [ADDR_W-1:0] clrIdx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    clr_state_t        state;
    clr_state_t        state_next;
    logic [ADDR_W-1:0] count;
    logic [BANK_W-1:0] bank;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sweep counter and bank latch; the bank is frozen for the whole sweep so
    // a bankSel change mid-sweep cannot redirect it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            bank  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clrStart) begin
                        count <= '0;
                        bank  <= bankSel;
                    end
                end
                SWEEP: begin
                    // Hold on the last index rather than wrapping.
                    if (count != LAST_IDX) begin
                        count <= count + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next = state;
        clrWe      = 1'b0;
        clrDone    = 1'b0;
        clrBusy    = 1'b1;
        case (state)
            IDLE: begin
                clrBusy = 1'b0;
                if (clrStart) begin
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                clrWe = 1'b1;
                if (count == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                clrDone    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign clrBank = bank;
    assign clrIdx  = count;

endmodule : reg_clr_seq
`default_nettype wire

// File: rtl/reg_file_banked.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_banked
// Description : Banked index-register file with single/pair reads and writes,
//               an increment-and-zero-test path and a sequenced bank clear.
//               Command priority per cycle: rst > sweep > write > increment.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_banked
    import reg_file_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int NUM_REGS  = DEF_NUM_REGS,
    parameter  int NUM_BANKS = DEF_NUM_BANKS,
    localparam int ADDR_W    = $clog2(NUM_REGS),
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BANK_W-1:0]   bankSel,
    input  logic                wrEn,
    input  logic                wrPair,
    input  logic [ADDR_W-1:0]   wrAddr,
    input  logic [2*DATA_W-1:0] wrData,
    input  logic                incEn,
    input  logic [ADDR_W-1:0]   incAddr,
    output logic                incValid,
    output logic                incZero,
    input  logic [ADDR_W-1:0]   rdAddr,
    output logic [DATA_W-1:0]   rdData,
    input  logic [ADDR_W-2:0]   rdPairAddr,
    output logic [2*DATA_W-1:0] rdPairData,
    input  logic                clrStart,
    output logic                clrBusy,
    output logic                clrDone,
    output logic                cmdReady
);

    // With a single bank the select line exists but must always hit bank 0.
    localparam logic [BANK_W-1:0] BANK_MASK = BANK_W'(NUM_BANKS - 1);

    logic [DATA_W-1:0] regs [NUM_BANKS][NUM_REGS];

    logic [BANK_W-1:0] bank;
    logic              clr_we;
    logic [BANK_W-1:0] clr_bank_raw;
    logic [BANK_W-1:0] clr_bank;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] wr_even_idx;
    logic [ADDR_W-1:0] wr_odd_idx;
    logic [ADDR_W-1:0] rd_even_idx;
    logic [ADDR_W-1:0] rd_odd_idx;
    logic [DATA_W-1:0] inc_sum;
    logic              wr_accept;
    logic              inc_accept;

    assign bank     = bankSel & BANK_MASK;
    assign clr_bank = clr_bank_raw & BANK_MASK;

    reg_clr_seq #(
        .NUM_REGS (NUM_REGS),
        .BANK_W   (BANK_W),
        .ADDR_W   (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clrStart (clrStart),
        .bankSel  (bankSel),
        .clrBusy  (clrBusy),
        .clrDone  (clrDone),
        .clrWe    (clr_we),
        .clrBank  (clr_bank_raw),
        .clrIdx   (clr_idx)
    );

    assign cmdReady = !clrBusy;

    // Pair indices: bit 0 of wrAddr is ignored for pair writes.
    assign wr_even_idx = ADDR_W'(evenIdx((IDX_FN_W-1)'(wrAddr[ADDR_W-1:1])));
    assign wr_odd_idx  = ADDR_W'(oddIdx((IDX_FN_W-1)'(wrAddr[ADDR_W-1:1])));
    assign rd_even_idx = ADDR_W'(evenIdx((IDX_FN_W-1)'(rdPairAddr)));
    assign rd_odd_idx  = ADDR_W'(oddIdx((IDX_FN_W-1)'(rdPairAddr)));

    // Increment wraps modulo 2^DATA_W; the carry is simply dropped.
    assign inc_sum = regs[bank][incAddr] + DATA_W'(1);

    // A write in the same cycle wins over an increment.
    assign wr_accept  = wrEn && cmdReady;
    assign inc_accept = incEn && !wrEn && cmdReady;

    // Reads are combinational with no bypass of same-cycle writes.
    assign rdData     = regs[bank][rdAddr];
    assign rdPairData = {regs[bank][rd_even_idx], regs[bank][rd_odd_idx]};

    // Storage update: reset, then sweep clear, then write, then increment
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    regs[b][r] <= '0;
                end
            end
        end else if (clr_we) begin
            regs[clr_bank][clr_idx] <= '0;
        end else if (wr_accept) begin
            if (wrPair) begin
                regs[bank][wr_even_idx] <= wrData[2*DATA_W-1:DATA_W];
                regs[bank][wr_odd_idx]  <= wrData[DATA_W-1:0];
            end else begin
                regs[bank][wrAddr] <= wrData[DATA_W-1:0];
            end
        end else if (inc_accept) begin
            regs[bank][incAddr] <= inc_sum;
        end
    end

    // Increment status: valid pulses once, zero flag holds until next increment
    always_ff @(posedge clk) begin
        if (rst) begin
            incValid <= 1'b0;
            incZero  <= 1'b0;
        end else begin
            incValid <= inc_accept;
            if (inc_accept) begin
                incZero <= (inc_sum == '0);
            end
        end
    end

endmodule : reg_file_banked
`default_nettype wire

// File: tb/tb_reg_file_banked.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_banked
// Description : Self-checking bench for reg_file_banked: default-parameter
//               instance checked every cycle against a behavioural model,
//               plus a DATA_W=8/NUM_REGS=8/NUM_BANKS=1 instance with literals.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_reg_file_banked;

    localparam int DW = 4;
    localparam int NR = 16;
    localparam int NB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: default parameters
    logic        rst, bankSel, wrEn, wrPair, incEn, clrStart;
    logic [3:0]  wrAddr, incAddr, rdAddr;
    logic [2:0]  rdPairAddr;
    logic [7:0]  wrData;
    logic [3:0]  rdData;
    logic [7:0]  rdPairData;
    logic        incValid, incZero, clrBusy, clrDone, cmdReady;

    // Instance B: DATA_W=8, NUM_REGS=8, NUM_BANKS=1
    logic        b_rst, b_bankSel, b_wrEn, b_wrPair, b_incEn, b_clrStart;
    logic [2:0]  b_wrAddr, b_incAddr, b_rdAddr;
    logic [1:0]  b_rdPairAddr;
    logic [15:0] b_wrData;
    logic [7:0]  b_rdData;
    logic [15:0] b_rdPairData;
    logic        b_incValid, b_incZero, b_clrBusy, b_clrDone, b_cmdReady;

    reg_file_banked u_dut (
        .clk(clk), .rst(rst), .bankSel(bankSel), .wrEn(wrEn), .wrPair(wrPair),
        .wrAddr(wrAddr), .wrData(wrData), .incEn(incEn), .incAddr(incAddr),
        .incValid(incValid), .incZero(incZero), .rdAddr(rdAddr), .rdData(rdData),
        .rdPairAddr(rdPairAddr), .rdPairData(rdPairData), .clrStart(clrStart),
        .clrBusy(clrBusy), .clrDone(clrDone), .cmdReady(cmdReady)
    );

    reg_file_banked #(.DATA_W(8), .NUM_REGS(8), .NUM_BANKS(1)) u_dut_b (
        .clk(clk), .rst(b_rst), .bankSel(b_bankSel), .wrEn(b_wrEn), .wrPair(b_wrPair),
        .wrAddr(b_wrAddr), .wrData(b_wrData), .incEn(b_incEn), .incAddr(b_incAddr),
        .incValid(b_incValid), .incZero(b_incZero), .rdAddr(b_rdAddr), .rdData(b_rdData),
        .rdPairAddr(b_rdPairAddr), .rdPairData(b_rdPairData), .clrStart(b_clrStart),
        .clrBusy(b_clrBusy), .clrDone(b_clrDone), .cmdReady(b_cmdReady)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model of instance A. A clear started at the edge ending
    // cycle S occupies cycles S+1 .. S+NR+1, wiping register k at the edge
    // ending cycle S+1+k; the final occupied cycle is the done cycle.
    // ------------------------------------------------------------------
    logic [3:0] mdl [NB][NR];
    bit         mdl_live      = 0;
    bit         clr_active    = 0;
    int         clr_start     = 0;
    int         clr_bank      = 0;
    bit         exp_inc_valid = 0;
    bit         exp_inc_zero  = 0;
    int         cyc           = 0;

    always @(posedge clk) begin
        int c;
        int p;
        c   = cyc;
        cyc = cyc + 1;
        if (rst) begin
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < NR; r++)
                    mdl[b][r] = '0;
            clr_active    = 0;
            exp_inc_valid = 0;
            exp_inc_zero  = 0;
            mdl_live      = 1;
        end else if (mdl_live) begin
            exp_inc_valid = 0;
            if (clr_active) begin
                if (c <= clr_start + NR) mdl[clr_bank][c - clr_start - 1] = '0;
                else                     clr_active = 0;
            end else begin
                if (wrEn) begin
                    if (wrPair) begin
                        p = wrAddr / 2;
                        mdl[bankSel][2*p]   = wrData[7:4];
                        mdl[bankSel][2*p+1] = wrData[3:0];
                    end else begin
                        mdl[bankSel][wrAddr] = wrData[3:0];
                    end
                end else if (incEn) begin
                    mdl[bankSel][incAddr] = 4'((int'(mdl[bankSel][incAddr]) + 1) % (1 << DW));
                    exp_inc_valid = 1;
                    exp_inc_zero  = (mdl[bankSel][incAddr] == 0);
                end
                if (clrStart) begin
                    clr_active = 1;
                    clr_start  = c;
                    clr_bank   = bankSel;
                end
            end
        end
    end

    // Per-cycle comparison of instance A against the model
    always @(negedge clk) begin
        if (mdl_live) begin
            check("rdData",     16'(rdData),     16'(mdl[bankSel][rdAddr]));
            check("rdPairData", 16'(rdPairData),
                  16'({mdl[bankSel][2*rdPairAddr], mdl[bankSel][2*rdPairAddr+1]}));
            check("incValid",   16'(incValid),   16'(exp_inc_valid));
            check("incZero",    16'(incZero),    16'(exp_inc_zero));
            check("clrBusy",    16'(clrBusy),    16'(clr_active));
            check("clrDone",    16'(clrDone),    16'(clr_active && (cyc == clr_start + NR + 1)));
            check("cmdReady",   16'(cmdReady),   16'(!clr_active));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        wrEn = 0; incEn = 0; clrStart = 0; wrPair = 0;
        b_wrEn = 0; b_incEn = 0; b_clrStart = 0; b_wrPair = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int done_at;
        rst = 1; bankSel = 0; wrAddr = 0; incAddr = 0; rdAddr = 0; rdPairAddr = 0; wrData = 0;
        b_rst = 1; b_bankSel = 0; b_wrAddr = 0; b_incAddr = 0; b_rdAddr = 0;
        b_rdPairAddr = 0; b_wrData = 0;
        quiet();
        step();
        rst = 0; b_rst = 0;

        // Reset state and every register of both banks
        check("rst_cmdReady", 16'(cmdReady), 16'd1);
        check("rst_clrBusy",  16'(clrBusy),  16'd0);
        check("rst_incValid", 16'(incValid), 16'd0);
        check("rst_incZero",  16'(incZero),  16'd0);
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < NR; i++) begin
                bankSel = 1'(b); rdAddr = 4'(i); rdPairAddr = 3'(i / 2);
                #1;
                check("rst_read", 16'(rdData), 16'h0);
                step();
            end
        end

        // Pair write into bank 1; same-cycle read sees the old value
        bankSel = 1; wrEn = 1; wrPair = 1; wrAddr = 5; wrData = 8'hA7; rdAddr = 4;
        #1;
        check("no_bypass", 16'(rdData), 16'h0);
        step(); quiet();
        rdAddr = 4; #1; check("pair_even", 16'(rdData), 16'hA);
        rdAddr = 5; #1; check("pair_odd",  16'(rdData), 16'h7);
        rdPairAddr = 2; #1; check("pair_read", 16'(rdPairData), 16'hA7);
        step();
        bankSel = 0; rdAddr = 4; #1; check("bank0_r4", 16'(rdData), 16'h0);
        rdAddr = 5; #1; check("bank0_r5", 16'(rdData), 16'h0);
        step();

        // Increment through wrap, then write-over-increment
        bankSel = 0; wrEn = 1; wrAddr = 3; wrData = 8'h0E;
        step(); quiet();
        incEn = 1; incAddr = 3; rdAddr = 3;
        step(); quiet();
        check("inc1_valid", 16'(incValid), 16'd1);
        check("inc1_zero",  16'(incZero),  16'd0);
        check("inc1_data",  16'(rdData),   16'hF);
        incEn = 1;
        step(); quiet();
        check("inc2_valid", 16'(incValid), 16'd1);
        check("inc2_zero",  16'(incZero),  16'd1);
        check("inc2_data",  16'(rdData),   16'h0);
        step();
        check("inc_valid_pulse", 16'(incValid), 16'd0);
        check("inc_zero_held",   16'(incZero),  16'd1);
        wrEn = 1; wrAddr = 3; wrData = 8'h09; incEn = 1; incAddr = 3;
        step(); quiet();
        check("wr_over_inc_data",  16'(rdData),   16'h9);
        check("wr_over_inc_valid", 16'(incValid), 16'd0);

        // Fill both banks with a known pattern
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < NR; i++) begin
                bankSel = 1'(b); wrEn = 1; wrAddr = 4'(i); wrData = 8'((i*3 + b*5 + 1) & 15);
                step();
            end
        end
        quiet();

        // Clear bank 1; mid-sweep: bankSel flips to 0, a write and a new clrStart
        bankSel = 1; clrStart = 1;
        step(); quiet();
        n = 0; done_at = 0;
        while (clrBusy === 1'b1 && n < 40) begin
            n++;
            if (clrDone === 1'b1) done_at = n;
            if (n == 5) begin
                bankSel = 0; wrEn = 1; wrAddr = 2; wrData = 8'h0F; clrStart = 1;
            end
            step(); quiet();
        end
        check("clr_busy_cycles", 16'(n),       16'd17);
        check("clr_done_cycle",  16'(done_at), 16'd17);
        check("clr_ready_back",  16'(cmdReady), 16'd1);
        bankSel = 0; rdAddr = 2;  #1; check("clr_drop_wr",   16'(rdData), 16'h7);
        rdAddr = 15; #1; check("clr_bank0_keep", 16'(rdData), 16'hE);
        step();
        bankSel = 1; rdAddr = 2;  #1; check("clr_bank1_r2",  16'(rdData), 16'h0);
        rdAddr = 15; #1; check("clr_bank1_r15", 16'(rdData), 16'h0);
        step();
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < NR; i++) begin
                bankSel = 1'(b); rdAddr = 4'(i); rdPairAddr = 3'(i / 2);
                step();
            end
        end

        // Reset while the sweep is at index 6
        bankSel = 0; wrEn = 1; wrAddr = 0; wrData = 8'h05; step();
        bankSel = 1; wrAddr = 9; wrData = 8'h0C; step();
        quiet();
        bankSel = 0; clrStart = 1;
        step(); quiet();
        repeat (6) step();
        rst = 1;
        step();
        rst = 0;
        check("rst_sweep_busy",  16'(clrBusy),  16'd0);
        check("rst_sweep_done",  16'(clrDone),  16'd0);
        check("rst_sweep_ready", 16'(cmdReady), 16'd1);
        for (int k = 0; k < 20; k++) begin
            step();
            check("rst_sweep_no_done", 16'(clrDone), 16'd0);
        end
        bankSel = 1; rdAddr = 9;  #1; check("rst_bank1_r9",  16'(rdData), 16'h0);
        step();
        bankSel = 0; rdAddr = 10; #1; check("rst_bank0_r10", 16'(rdData), 16'h0);
        step();

        // Instance B: 8-bit wrap, pair path and 9-cycle clear
        b_wrEn = 1; b_wrAddr = 2; b_wrData = 16'h00FF;
        step(); quiet();
        b_incEn = 1; b_incAddr = 2; b_rdAddr = 2;
        step(); quiet();
        check("b_inc_valid", 16'(b_incValid), 16'd1);
        check("b_inc_zero",  16'(b_incZero),  16'd1);
        check("b_inc_data",  16'(b_rdData),   16'h00);
        b_wrEn = 1; b_wrPair = 1; b_wrAddr = 3; b_wrData = 16'h1234;
        step(); quiet();
        b_rdPairAddr = 1; #1;
        check("b_pair_read", b_rdPairData, 16'h1234);
        b_clrStart = 1;
        step(); quiet();
        n = 0; done_at = 0;
        while (b_clrBusy === 1'b1 && n < 40) begin
            n++;
            if (b_clrDone === 1'b1) done_at = n;
            step();
        end
        check("b_clr_busy_cycles", 16'(n),       16'd9);
        check("b_clr_done_cycle",  16'(done_at), 16'd9);
        check("b_clr_pair_zero",   b_rdPairData, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_file_banked
`default_nettype wire
